// File: rtl/divider_seq.sv
// Sequential restoring divider: 2*bw-bit dividend / bw-bit divisor -> bw-bit quotient and remainder.
// One shift/subtract step per cycle behind a start/busy/done handshake, with divide-by-zero and overflow prechecks.
module divider_seq #(
  parameter int bw = 16
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            start,
  input  logic [2*bw-1:0] dividend,
  input  logic [bw-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [bw-1:0]   quo,
  output logic [bw-1:0]   rem,
  output logic            div_zero,
  output logic            ovf
);

  localparam int CW = $clog2(bw + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [bw:0]    p_r;
  logic [bw-1:0]  q_r;
  logic [bw-1:0]  d_r;
  logic [CW-1:0]  cnt_r;

  logic [bw:0]    t_s;
  logic [bw:0]    p_step_s;
  logic [bw-1:0]  q_step_s;
  logic           last_step_s;
  logic           zero_s;
  logic           over_s;

  // Next-state logic, one restoring step, and operand prechecks
  always_comb begin
    state_s     = state_r;
    t_s         = {p_r[bw-1:0], q_r[bw-1]};
    p_step_s    = t_s;
    q_step_s    = {q_r[bw-2:0], 1'b0};
    last_step_s = (cnt_r == CW'(bw - 1));
    zero_s      = (divisor == {bw{1'b0}});
    // An upper half >= divisor means the quotient needs more than bw bits
    over_s      = (dividend[2*bw-1:bw] >= divisor);

    // T keeps bw+1 bits so the bit shifted out of P still takes part in the compare
    if (t_s >= {1'b0, d_r}) begin
      p_step_s = t_s - {1'b0, d_r};
      q_step_s = {q_r[bw-2:0], 1'b1};
    end else begin
      p_step_s = t_s;
      q_step_s = {q_r[bw-2:0], 1'b0};
    end

    case (state_r)
      IDLE: begin
        if (start && !zero_s && !over_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_step_s) begin
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered busy flag
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == RUN);
    end
  end

  // Datapath: operand latch, shift/subtract iteration and result/flag registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      p_r      <= {(bw+1){1'b0}};
      q_r      <= {bw{1'b0}};
      d_r      <= {bw{1'b0}};
      cnt_r    <= {CW{1'b0}};
      done     <= 1'b0;
      quo      <= {bw{1'b0}};
      rem      <= {bw{1'b0}};
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (zero_s) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
              ovf      <= 1'b0;
              quo      <= {bw{1'b1}};
              rem      <= {bw{1'b0}};
            end else if (over_s) begin
              done     <= 1'b1;
              div_zero <= 1'b0;
              ovf      <= 1'b1;
              quo      <= {bw{1'b1}};
              rem      <= {bw{1'b0}};
            end else begin
              p_r   <= {1'b0, dividend[2*bw-1:bw]};
              q_r   <= dividend[bw-1:0];
              d_r   <= divisor;
              cnt_r <= {CW{1'b0}};
            end
          end
        end
        RUN: begin
          p_r   <= p_step_s;
          q_r   <= q_step_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_step_s) begin
            quo      <= q_step_s;
            rem      <= p_step_s[bw-1:0];
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq (bw=16): scoreboard of reference results,
// latency/busy/hold checks, error paths, back-to-back starts and mid-run reset.
module tb_divider_seq;

  localparam int BW = 16;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          start = 1'b0;
  logic [2*BW-1:0] dividend = '0;
  logic [BW-1:0] divisor = '0;
  logic          busy, done, div_zero, ovf;
  logic [BW-1:0] quo, rem;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [BW-1:0] quo;
    logic [BW-1:0] rem;
    logic          dz;
    logic          ov;
  } exp_t;

  exp_t sb[$];

  divider_seq #(.bw(BW)) dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t model(input logic [2*BW-1:0] a, input logic [BW-1:0] b);
    exp_t e;
    logic [2*BW-1:0] qq, rr;
    e = '0;
    if (b == 16'd0) begin
      e.quo = 16'hFFFF; e.rem = 16'd0; e.dz = 1'b1; e.ov = 1'b0;
    end else if (a[2*BW-1:BW] >= b) begin
      e.quo = 16'hFFFF; e.rem = 16'd0; e.dz = 1'b0; e.ov = 1'b1;
    end else begin
      qq = a / {16'd0, b};
      rr = a % {16'd0, b};
      e.quo = qq[BW-1:0]; e.rem = rr[BW-1:0]; e.dz = 1'b0; e.ov = 1'b0;
    end
    return e;
  endfunction

  // One operation: n counts negedges after the accept edge until done is seen
  task automatic run_op(input logic [2*BW-1:0] a, input logic [BW-1:0] b,
                        input int exp_n, input int exp_busy, input string nm);
    exp_t e;
    int n, busy_n, hold_bad;
    logic [BW-1:0] q0, r0;
    sb.push_back(model(a, b));
    @(negedge CLK);
    dividend = a; divisor = b; start = 1'b1;
    q0 = quo; r0 = rem;
    @(negedge CLK);
    start = 1'b0;
    dividend = $urandom(); divisor = 16'($urandom());
    n = 1; busy_n = 0; hold_bad = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_n++;
      if (quo !== q0 || rem !== r0) hold_bad++;
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n !== exp_n) begin
      errors++; $display("FAIL %s latency: got %0d, expected %0d", nm, n, exp_n);
    end
    checks++;
    if (busy_n !== exp_busy) begin
      errors++; $display("FAIL %s busy cycles: got %0d, expected %0d", nm, busy_n, exp_busy);
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++; $display("FAIL %s hold during run: %0d cycles changed, expected 0", nm, hold_bad);
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s timeout: done not seen, expected quo=%h rem=%h", nm, e.quo, e.rem);
    end else if ({quo, rem, div_zero, ovf} !== {e.quo, e.rem, e.dz, e.ov}) begin
      errors++;
      $display("FAIL %s result: got quo=%h rem=%h dz=%b ovf=%b, expected quo=%h rem=%h dz=%b ovf=%b",
               nm, quo, rem, div_zero, ovf, e.quo, e.rem, e.dz, e.ov);
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || quo !== e.quo || rem !== e.rem) begin
      errors++;
      $display("FAIL %s pulse/hold: got done=%b quo=%h rem=%h, expected done=0 quo=%h rem=%h",
               nm, done, quo, rem, e.quo, e.rem);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, quo, rem, div_zero, ovf} !== 36'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b quo=%h rem=%h dz=%b ovf=%b, expected all 0",
               busy, done, quo, rem, div_zero, ovf);
    end
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
  endtask

  task automatic test_basic();
    run_op(32'd100000, 16'd7, 17, 16, "basic_100000_7");
  endtask

  task automatic test_extremes();
    run_op(32'hFFFE0001, 16'hFFFF, 17, 16, "max_ffff");
    run_op(32'h0000FFFF, 16'd1, 17, 16, "div_by_one");
  endtask

  task automatic test_errors();
    run_op(32'd123, 16'd0, 1, 0, "div_zero");
    run_op(32'h00070000, 16'd7, 1, 0, "overflow");
  endtask

  task automatic test_random();
    logic [BW-1:0] b, hi;
    for (int i = 0; i < 6; i++) begin
      b  = 16'($urandom_range(1, 65535));
      hi = 16'($urandom_range(0, int'(b) - 1));
      run_op({hi, 16'($urandom())}, b, 17, 16, "random");
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n, got, t_prev;
    @(negedge CLK);
    dividend = 32'd1000; divisor = 16'd10; start = 1'b1;
    sb.push_back(model(32'd1000, 16'd10));
    n = 0; got = 0; t_prev = 0;
    while (got < 2 && n < 100) begin
      @(negedge CLK);
      n++;
      if (done === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if ({quo, rem, div_zero, ovf} !== {e.quo, e.rem, e.dz, e.ov}) begin
          errors++;
          $display("FAIL b2b result %0d: got quo=%h rem=%h dz=%b ovf=%b, expected quo=%h rem=%h dz=%b ovf=%b",
                   got, quo, rem, div_zero, ovf, e.quo, e.rem, e.dz, e.ov);
        end
        checks++;
        if (n - t_prev !== 17) begin
          errors++; $display("FAIL b2b spacing %0d: got %0d cycles, expected 17", got, n - t_prev);
        end
        t_prev = n;
        got++;
        if (got == 1) begin
          dividend = 32'd65535; divisor = 16'd256;
          sb.push_back(model(32'd65535, 16'd256));
        end else begin
          start = 1'b0;
        end
      end else begin
        dividend = $urandom(); divisor = 16'($urandom());
      end
    end
    start = 1'b0;
    checks++;
    if (got !== 2) begin
      errors++; $display("FAIL b2b timeout: got %0d results, expected 2", got);
      sb.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset_mid_run();
    int stray;
    @(negedge CLK);
    dividend = 32'd100000; divisor = 16'd7; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (7) @(negedge CLK);
    #1 RESETn = 1'b0;
    #1;
    checks++;
    if ({busy, done, quo, rem, div_zero, ovf} !== 36'd0) begin
      errors++;
      $display("FAIL mid-run reset: got busy=%b done=%b quo=%h rem=%h dz=%b ovf=%b, expected all 0",
               busy, done, quo, rem, div_zero, ovf);
    end
    @(negedge CLK);
    RESETn = 1'b1;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL post-reset idle: %0d cycles with done/busy, expected 0", stray);
    end
    run_op(32'd100000, 16'd7, 17, 16, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
